// File: rtl/fb_scanout_pkg.sv
// Framebuffer geometry (mirrors the GPU's fb_defs.v), scan-out FSM state type and address helper.
// Shared by the fb_scanout top and its line-buffer sub-module.
package fb_scanout_pkg;

    localparam logic [11:0] FB_OFFSET    = 12'h100;
    localparam int          FB_BYTES     = 256;
    localparam int          FB_WIDTH     = 64;
    localparam int          FB_HEIGHT    = 32;
    localparam int          FB_ROW_BYTES = 8;

    localparam logic [5:0] X_LAST    = 6'(FB_WIDTH - 1);
    localparam logic [4:0] ROW_LAST  = 5'(FB_HEIGHT - 1);
    localparam logic [2:0] BYTE_LAST = 3'(FB_ROW_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        EMIT,
        DONE
    } scan_state_t;

    // Row/byte concatenation is 8 bits, so the result always stays inside the framebuffer window.
    function automatic logic [11:0] fb_addr(input logic [4:0] row, input logic [2:0] idx);
        return FB_OFFSET + {4'h0, row, idx};
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Bus bundle between fb_scanout (master) and its environment: frame control,
// framebuffer read port and the pixel stream towards the panel driver.
interface fb_scanout_if;

    logic        scan_start;
    logic        scan_busy;
    logic        scan_done;
    logic        scan_mem_read;
    logic [11:0] scan_mem_read_addr;
    logic [7:0]  scan_mem_read_data;
    logic        scan_mem_read_ack;
    logic        pix_valid;
    logic        pix_data;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;

    modport master (
        input  scan_start,
        output scan_busy,
        output scan_done,
        output scan_mem_read,
        output scan_mem_read_addr,
        input  scan_mem_read_data,
        input  scan_mem_read_ack,
        output pix_valid,
        output pix_data,
        input  pix_ready,
        output pix_sof,
        output pix_eol
    );

    modport slave (
        output scan_start,
        input  scan_busy,
        input  scan_done,
        input  scan_mem_read,
        input  scan_mem_read_addr,
        output scan_mem_read_data,
        output scan_mem_read_ack,
        input  pix_valid,
        input  pix_data,
        output pix_ready,
        input  pix_sof,
        input  pix_eol
    );

endinterface

// File: rtl/fb_line_buf.sv
// One-row line buffer: eight bytes written by byte index, read as a single pixel by x
// with the MSB of each byte being the leftmost pixel. Contents are not reset.
module fb_line_buf
    import fb_scanout_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_x,
    output logic       rd_bit
);

    logic [7:0] line_mem [FB_ROW_BYTES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_bit = line_mem[rd_x[5:3]][~rd_x[2:0]];

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: fetches one 8-byte row, then streams its 64 pixels in raster order.
// Optional FB_SCANOUT_ROW_DOUBLE_EN emits each fetched row twice (64x64 output, no refetch).
module fb_scanout
    import fb_scanout_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fb_scanout_if.master bus
);

    scan_state_t state, state_n;
    logic [4:0]  row, row_n;
    logic [2:0]  byte_idx, byte_n;
    logic [5:0]  x, x_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic        rd, rd_n;
    logic [11:0] addr, addr_n;
    logic        valid, valid_n;
    logic        data, data_n;
    logic        sof, sof_n;
    logic        eol, eol_n;
    logic        buf_we;
    logic        buf_bit;
    logic        row_end;
    logic [5:0]  rd_x;

`ifdef FB_SCANOUT_ROW_DOUBLE_EN
    logic pass, pass_n;
    assign row_end = (x == X_LAST) && pass;
`else
    assign row_end = (x == X_LAST);
`endif

    // The pixel register is loaded one position ahead of x once a pixel is on display.
    assign rd_x = valid ? x + 6'd1 : x;

    fb_line_buf u_line_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_idx  (byte_idx),
        .wr_data (bus.scan_mem_read_data),
        .rd_x    (rd_x),
        .rd_bit  (buf_bit)
    );

    always_comb begin
        state_n = state;
        row_n   = row;
        byte_n  = byte_idx;
        x_n     = x;
        busy_n  = busy;
        done_n  = 1'b0;
        rd_n    = rd;
        addr_n  = addr;
        valid_n = valid;
        data_n  = data;
        sof_n   = sof;
        eol_n   = eol;
        buf_we  = 1'b0;
`ifdef FB_SCANOUT_ROW_DOUBLE_EN
        pass_n  = pass;
`endif
        case (state)
            IDLE: begin
                // A start landing on the scan_done pulse belongs to the finished frame.
                if (bus.scan_start && !done) begin
                    row_n   = 5'd0;
                    byte_n  = 3'd0;
                    busy_n  = 1'b1;
                    state_n = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                rd_n    = 1'b1;
                addr_n  = fb_addr(row, byte_idx);
                state_n = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (rd && bus.scan_mem_read_ack) begin
                    buf_we = 1'b1;
                    rd_n   = 1'b0;
                    if (byte_idx != BYTE_LAST) begin
                        byte_n  = byte_idx + 3'd1;
                        state_n = FETCH_REQ;
                    end else begin
                        x_n     = 6'd0;
                        state_n = EMIT;
`ifdef FB_SCANOUT_ROW_DOUBLE_EN
                        pass_n  = 1'b0;
`endif
                    end
                end
            end
            EMIT: begin
                if (!valid) begin
                    valid_n = 1'b1;
                    data_n  = buf_bit;
                    sof_n   = (row == 5'd0);
                    eol_n   = 1'b0;
                end else if (bus.pix_ready) begin
                    if (row_end) begin
                        valid_n = 1'b0;
                        data_n  = 1'b0;
                        sof_n   = 1'b0;
                        eol_n   = 1'b0;
                        // Issue the next row's first read on the last pixel's edge to keep the row period tight.
                        if (row != ROW_LAST) begin
                            row_n   = row + 5'd1;
                            byte_n  = 3'd0;
                            rd_n    = 1'b1;
                            addr_n  = fb_addr(row + 5'd1, 3'd0);
                            state_n = FETCH_WAIT;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        x_n    = x + 6'd1;
                        data_n = buf_bit;
                        sof_n  = 1'b0;
                        eol_n  = (rd_x == X_LAST);
`ifdef FB_SCANOUT_ROW_DOUBLE_EN
                        if (x == X_LAST) begin
                            pass_n = 1'b1;
                        end
`endif
                    end
                end
            end
            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row      <= 5'd0;
            byte_idx <= 3'd0;
            x        <= 6'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd       <= 1'b0;
            addr     <= 12'd0;
            valid    <= 1'b0;
            data     <= 1'b0;
            sof      <= 1'b0;
            eol      <= 1'b0;
`ifdef FB_SCANOUT_ROW_DOUBLE_EN
            pass     <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            row      <= row_n;
            byte_idx <= byte_n;
            x        <= x_n;
            busy     <= busy_n;
            done     <= done_n;
            rd       <= rd_n;
            addr     <= addr_n;
            valid    <= valid_n;
            data     <= data_n;
            sof      <= sof_n;
            eol      <= eol_n;
`ifdef FB_SCANOUT_ROW_DOUBLE_EN
            pass     <= pass_n;
`endif
        end
    end

    assign bus.scan_busy          = busy;
    assign bus.scan_done          = done;
    assign bus.scan_mem_read      = rd;
    assign bus.scan_mem_read_addr = addr;
    assign bus.pix_valid          = valid;
    assign bus.pix_data           = data;
    assign bus.pix_sof            = sof;
    assign bus.pix_eol            = eol;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: memory model with optional ack delay, a negedge stream
// monitor, and one task per scenario. Honours FB_SCANOUT_ROW_DOUBLE_EN.
module tb_fb_scanout;

`ifdef FB_SCANOUT_ROW_DOUBLE_EN
    localparam int REPS = 2;
`else
    localparam int REPS = 1;
`endif
    localparam int TOTAL_PIX  = 2048 * REPS;
    localparam int ROW_PERIOD = 16 + 64 * REPS;
    localparam int DONE_CYC   = 2 + 32 * ROW_PERIOD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fb_scanout_if bus ();

    fb_scanout dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Memory model: ack after cur_delay cycles of a pending request (0 = same cycle).
    logic [7:0]  mem [256];
    int unsigned wait_cnt  = 0;
    int unsigned cur_delay = 0;
    bit          ack_random = 1'b0;

    assign bus.scan_mem_read_ack  = bus.scan_mem_read && (wait_cnt == cur_delay);
    assign bus.scan_mem_read_data = mem[bus.scan_mem_read_addr[7:0]];

    always @(posedge clk) begin
        if (!bus.scan_mem_read || bus.scan_mem_read_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (bus.scan_mem_read && bus.scan_mem_read_ack)
            cur_delay <= ack_random ? $urandom_range(0, 5) : 0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    bit          mon_en = 1'b0;
    int          start_cyc = 0;
    logic [16:0] read_pattern;
    int read_count, addr_err, hold_err, gap_err, rd_high;
    logic [11:0] first_addr;
    int pix_count, pix_err, stall_err, ones_count, eol_count, sof_count;
    int first_valid, done_cyc;
    logic first_data, first_sof;
    logic prev_rd, prev_ack, prev_valid, prev_ready;
    logic [11:0] prev_addr;
    logic [3:0]  prev_bits;

    always @(negedge clk) begin
        int rel, n, px, py;
        logic [7:0] b;
        logic expd;
        rel = cyc - start_cyc;
        if (mon_en) begin
            if (rel >= 0 && rel <= 16) read_pattern[rel[4:0]] = bus.scan_mem_read;
            if (bus.scan_mem_read) rd_high++;
            if (bus.scan_mem_read && bus.scan_mem_read_ack) begin
                if (read_count == 0) first_addr = bus.scan_mem_read_addr;
                if (bus.scan_mem_read_addr !== (12'h100 | 12'(read_count % 256))) addr_err++;
                read_count++;
            end
            if (bus.scan_mem_read && prev_rd && !prev_ack && bus.scan_mem_read_addr !== prev_addr) hold_err++;
            if (prev_rd && prev_ack && bus.scan_mem_read) gap_err++;
            if (bus.pix_valid && first_valid < 0) first_valid = rel;
            if (prev_valid && !prev_ready &&
                {bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_eol} !== prev_bits) stall_err++;
            if (bus.pix_valid && bus.pix_ready) begin
                n  = pix_count;
                px = n % 64;
                py = (n / 64) / REPS;
                b  = mem[py * 8 + px / 8];
                expd = b[7 - (px % 8)];
                if (n == 0) begin
                    first_data = bus.pix_data;
                    first_sof  = bus.pix_sof;
                end
                if (bus.pix_data !== expd || bus.pix_sof !== (n == 0) || bus.pix_eol !== (px == 63)) pix_err++;
                if (bus.pix_data) ones_count++;
                if (bus.pix_eol) eol_count++;
                if (bus.pix_sof) sof_count++;
                pix_count++;
            end
            if (bus.scan_done && done_cyc < 0) done_cyc = rel;
            prev_rd    = bus.scan_mem_read;
            prev_ack   = bus.scan_mem_read_ack;
            prev_addr  = bus.scan_mem_read_addr;
            prev_valid = bus.pix_valid;
            prev_ready = bus.pix_ready;
            prev_bits  = {bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_eol};
        end
    end

    bit done_timeout;
    bit stop_ready;

    task automatic clear_monitor();
        read_pattern = '0;
        read_count = 0; addr_err = 0; hold_err = 0; gap_err = 0; rd_high = 0;
        first_addr = '0;
        pix_count = 0; pix_err = 0; stall_err = 0; ones_count = 0; eol_count = 0; sof_count = 0;
        first_valid = -1; done_cyc = -1;
        first_data = 1'b0; first_sof = 1'b0;
        prev_rd = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
        prev_addr = '0; prev_bits = '0;
    endtask

    // Raises scan_start so that it is sampled at the next edge, which becomes cycle 0.
    task automatic start_frame();
        @(posedge clk);
        #1;
        clear_monitor();
        start_cyc = cyc + 1;
        mon_en = 1'b1;
        bus.scan_start = 1'b1;
        @(posedge clk);
        #1;
        bus.scan_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        done_timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.scan_done) begin
                done_timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.scan_busy, bus.scan_done, bus.scan_mem_read} !== 3'b000)
            $display("[TB] FAIL reset_ctrl: busy/done/read = %b, expected 000", {bus.scan_busy, bus.scan_done, bus.scan_mem_read});
        else passed++;
        total++;
        if ({bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_eol} !== 4'b0000)
            $display("[TB] FAIL reset_pix: valid/data/sof/eol = %b, expected 0000", {bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_eol});
        else passed++;
        total++;
        if (bus.scan_mem_read_addr !== 12'h000)
            $display("[TB] FAIL reset_addr: got %h, expected 000", bus.scan_mem_read_addr);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_pixel();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h80;
        start_frame();
        @(negedge clk);
        total++;
        if (bus.scan_busy !== 1'b1) $display("[TB] FAIL busy_after_start: got %b, expected 1", bus.scan_busy);
        else passed++;
        wait_done(6000);
        total++;
        if (done_timeout !== 1'b0) $display("[TB] FAIL single_done_timeout: scan_done not seen within budget");
        else passed++;
        total++;
        if (bus.scan_busy !== 1'b0) $display("[TB] FAIL busy_at_done: got %b, expected 0", bus.scan_busy);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (read_pattern !== 17'h0AAAA) $display("[TB] FAIL read_pattern: got %h, expected 0aaaa", read_pattern);
        else passed++;
        total++;
        if (first_valid !== 17) $display("[TB] FAIL first_valid_cycle: got %0d, expected 17", first_valid);
        else passed++;
        total++;
        if ({first_data, first_sof} !== 2'b11) $display("[TB] FAIL first_pixel: data/sof = %b, expected 11", {first_data, first_sof});
        else passed++;
        total++;
        if (ones_count !== REPS) $display("[TB] FAIL lit_pixels: got %0d, expected %0d", ones_count, REPS);
        else passed++;
        total++;
        if (pix_count !== TOTAL_PIX) $display("[TB] FAIL single_pix_count: got %0d, expected %0d", pix_count, TOTAL_PIX);
        else passed++;
        total++;
        if (pix_err !== 0) $display("[TB] FAIL single_pix_data: %0d bad pixels, expected 0", pix_err);
        else passed++;
        total++;
        if (done_cyc !== DONE_CYC) $display("[TB] FAIL single_done_cycle: got %0d, expected %0d", done_cyc, DONE_CYC);
        else passed++;
        total++;
        if (read_count !== 256) $display("[TB] FAIL single_reads: got %0d, expected 256", read_count);
        else passed++;
    endtask

    task automatic test_checkerboard();
        for (int i = 0; i < 256; i++) mem[i] = ((i / 8) % 2 == 0) ? 8'hAA : 8'h55;
        start_frame();
        wait_done(6000);
        total++;
        if (done_timeout !== 1'b0) $display("[TB] FAIL checker_done_timeout: scan_done not seen within budget");
        else passed++;
        // A start coinciding with the scan_done pulse must be ignored.
        bus.scan_start = 1'b1;
        @(posedge clk);
        #1;
        bus.scan_start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.scan_busy, bus.scan_mem_read} !== 2'b00)
            $display("[TB] FAIL start_on_done: busy/read = %b, expected 00", {bus.scan_busy, bus.scan_mem_read});
        else passed++;
        total++;
        if (pix_err !== 0) $display("[TB] FAIL checker_data: %0d bad pixels, expected 0", pix_err);
        else passed++;
        total++;
        if (eol_count !== 32 * REPS) $display("[TB] FAIL checker_eol: got %0d, expected %0d", eol_count, 32 * REPS);
        else passed++;
        total++;
        if (sof_count !== 1) $display("[TB] FAIL checker_sof: got %0d, expected 1", sof_count);
        else passed++;
        total++;
        if (pix_count !== TOTAL_PIX) $display("[TB] FAIL checker_pix_count: got %0d, expected %0d", pix_count, TOTAL_PIX);
        else passed++;
        total++;
        if (done_cyc !== DONE_CYC) $display("[TB] FAIL checker_done_cycle: got %0d, expected %0d", done_cyc, DONE_CYC);
        else passed++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        stop_ready = 1'b0;
        fork
            begin
                start_frame();
                wait_done(20000);
                stop_ready = 1'b1;
            end
            begin
                while (!stop_ready) begin
                    @(posedge clk);
                    #1;
                    bus.pix_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.pix_ready = 1'b1;
        total++;
        if (done_timeout !== 1'b0) $display("[TB] FAIL stall_done_timeout: scan_done not seen within budget");
        else passed++;
        total++;
        if (stall_err !== 0) $display("[TB] FAIL stall_stability: %0d unstable stalled cycles, expected 0", stall_err);
        else passed++;
        total++;
        if (pix_count !== TOTAL_PIX) $display("[TB] FAIL stall_pix_count: got %0d, expected %0d", pix_count, TOTAL_PIX);
        else passed++;
        total++;
        if (pix_err !== 0) $display("[TB] FAIL stall_data: %0d bad pixels, expected 0", pix_err);
        else passed++;
    endtask

    task automatic test_ack_delay();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        ack_random = 1'b1;
        start_frame();
        wait_done(12000);
        ack_random = 1'b0;
        total++;
        if (done_timeout !== 1'b0) $display("[TB] FAIL ack_done_timeout: scan_done not seen within budget");
        else passed++;
        total++;
        if (read_count !== 256) $display("[TB] FAIL ack_reads: got %0d, expected 256", read_count);
        else passed++;
        total++;
        if (addr_err !== 0) $display("[TB] FAIL ack_addr_order: %0d out-of-order addresses, expected 0", addr_err);
        else passed++;
        total++;
        if (hold_err !== 0) $display("[TB] FAIL ack_addr_hold: %0d address changes before ack, expected 0", hold_err);
        else passed++;
        total++;
        if (gap_err !== 0) $display("[TB] FAIL ack_read_gap: %0d back-to-back reads, expected 0", gap_err);
        else passed++;
        total++;
        if (pix_err !== 0) $display("[TB] FAIL ack_data: %0d bad pixels, expected 0", pix_err);
        else passed++;
        total++;
        if (pix_count !== TOTAL_PIX) $display("[TB] FAIL ack_pix_count: got %0d, expected %0d", pix_count, TOTAL_PIX);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int target;
        int mid_count;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
        target = 17 + 10 * ROW_PERIOD + 30;
        start_frame();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (cyc - start_cyc >= target) break;
        end
        mid_count = pix_count;
        total++;
        if (mid_count <= 10 * 64 * REPS || mid_count >= 11 * 64 * REPS)
            $display("[TB] FAIL mid_row10: %0d pixels before reset, expected within row 10", mid_count);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.scan_busy, bus.scan_done, bus.scan_mem_read} !== 3'b000)
            $display("[TB] FAIL midreset_ctrl: busy/done/read = %b, expected 000", {bus.scan_busy, bus.scan_done, bus.scan_mem_read});
        else passed++;
        total++;
        if ({bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_eol} !== 4'b0000)
            $display("[TB] FAIL midreset_pix: valid/data/sof/eol = %b, expected 0000", {bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_eol});
        else passed++;
        total++;
        if (bus.scan_mem_read_addr !== 12'h000)
            $display("[TB] FAIL midreset_addr: got %h, expected 000", bus.scan_mem_read_addr);
        else passed++;
        clear_monitor();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (rd_high !== 0) $display("[TB] FAIL midreset_no_reads: %0d read cycles after reset, expected 0", rd_high);
        else passed++;
        start_frame();
        wait_done(6000);
        total++;
        if (done_timeout !== 1'b0) $display("[TB] FAIL rescan_done_timeout: scan_done not seen within budget");
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (first_addr !== 12'h100) $display("[TB] FAIL rescan_first_addr: got %h, expected 100", first_addr);
        else passed++;
        total++;
        if (pix_err !== 0) $display("[TB] FAIL rescan_data: %0d bad pixels, expected 0", pix_err);
        else passed++;
        total++;
        if (pix_count !== TOTAL_PIX) $display("[TB] FAIL rescan_pix_count: got %0d, expected %0d", pix_count, TOTAL_PIX);
        else passed++;
        total++;
        if (done_cyc !== DONE_CYC) $display("[TB] FAIL rescan_done_cycle: got %0d, expected %0d", done_cyc, DONE_CYC);
        else passed++;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.scan_start = 1'b0;
        bus.pix_ready  = 1'b1;
        test_reset();
        test_single_pixel();
        test_checkerboard();
        test_stall();
        test_ack_delay();
        test_reset_mid_frame();
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Display scan-out stage directly downstream of the GPU. Reads the 64x32 monochrome framebuffer (256 bytes at 0x100–0x1FF) through a dedicated memory read port, one row at a time into an 8-byte line buffer. Emits pixels as a valid/ready stream in raster order to the display driver. Sits between main memory and the panel driver and runs alongside GPU clear/draw writes; it does not arbitrate against them.

## Interface
- No parameters; geometry constants come from the shared defines file.
- `clk` in 1 — system clock; all logic on rising edge.
- `rst` in 1 — synchronous reset, active-high.
- `scan_start` in 1 — single-cycle request to scan one frame; ignored while `scan_busy`.
- `scan_busy` out 1 — high from the cycle after an accepted start until `scan_done`.
- `scan_done` out 1 — one-cycle pulse after the last pixel of the frame is accepted.
- `scan_mem_read` out 1 — memory read request.
- `scan_mem_read_addr` out 12 — byte address, 0x100–0x1FF.
- `scan_mem_read_data` in 8 — read data, valid in the ack cycle.
- `scan_mem_read_ack` in 1 — read completion.
- `pix_valid` out 1 — pixel available.
- `pix_data` out 1 — pixel value; 1 = lit.
- `pix_ready` in 1 — downstream accepts the pixel.
- `pix_sof` out 1 — qualifies the current pixel as x=0, y=0 (first output row).
- `pix_eol` out 1 — qualifies the current pixel as x=63.

## Operation
- FSM states: IDLE, FETCH_REQ, FETCH_WAIT, EMIT, DONE.
- **IDLE**
  - `scan_start` sets row=0 and byte=0, then moves to FETCH_REQ.
- **FETCH_REQ**
  - Drives `scan_mem_read`=1 and `scan_mem_read_addr` = 0x100 + row*8 + byte.
  - Moves to FETCH_WAIT.
- **FETCH_WAIT**
  - Holds `scan_mem_read` and the address until `scan_mem_read_ack` is sampled high.
  - On ack: latches data into line buffer[byte] and drops `scan_mem_read` next cycle.
  - If byte<7: byte++, back to FETCH_REQ. If byte==7: go to EMIT with x=0.
  - Each read is a separate transaction; `scan_mem_read` is low for at least one cycle between reads.
- **EMIT**
  - `pix_data` = bit (7 − x%8) of buffer[x/8]; MSB is the leftmost pixel.
  - A pixel is transferred on an edge where `pix_valid && pix_ready`; x then increments.
  - After x=63 is transferred: if row<31, row++, byte=0, go to FETCH_REQ; otherwise go to DONE.
- **DONE**
  - Pulses `scan_done` for one cycle, then returns to IDLE.
- Counter widths: x is 6 bits, row is 5 bits, byte is 3 bits.
- Address arithmetic is 12-bit and never leaves 0x100–0x1FF.
- Frame contents are whatever memory holds at fetch time. Tearing against concurrent GPU writes is accepted.

## Timing
- Reset values:
  - `scan_busy`, `scan_done`, `scan_mem_read`, `pix_valid`, `pix_data`, `pix_sof`, `pix_eol` = 0.
  - `scan_mem_read_addr` = 0.
  - FSM = IDLE; line buffer contents are don't-care.
- All outputs are registered.
- `pix_valid`, `pix_data`, `pix_sof` and `pix_eol` must stay stable while `pix_valid && !pix_ready` (no retraction).
- In EMIT with `pix_ready` held high: one pixel per cycle.
- Reference memory timing: ack arrives the cycle after `scan_mem_read` rises. Start sampled at edge 0 gives:
  - `scan_mem_read` high in cycles 1, 3, …, 15.
  - First `pix_valid` in cycle 17.
  - Row period is 16+64 = 80 cycles.
  - `scan_done` at cycle 2562.
- Ack arriving while `scan_mem_read` is low is ignored.
- `rst` mid-frame: every output returns to its reset value on the next edge, with no further memory reads.
- `scan_start` coinciding with `scan_done` or DONE is ignored. A new start is accepted only in IDLE.

## Configuration
- `FB_SCANOUT_ROW_DOUBLE_EN`
  - Defined: every fetched row is emitted twice from the line buffer, with no refetch, giving a 64x64 output stream.
  - `pix_sof` is asserted only on the first emission of row 0.
  - `pix_eol` is asserted on both emissions.
  - Row period becomes 16+128 = 144 cycles; `scan_done` moves to cycle 4610.
  - Undefined: single emission, behaviour as above.

## Structure
- Framebuffer constants go in shared defines header `fb_defs.v`, included by both the GPU and this block:
  - `FB_OFFSET` = 'h100
  - `FB_BYTES` = 256
  - `FB_WIDTH` = 64
  - `FB_HEIGHT` = 32
  - `FB_ROW_BYTES` = 8
- Sub-module `fb_line_buf`: 8x8 register file with one write port (byte index, data, write enable) and a combinational bit-select read by x.
- FSM and counters remain in `fb_scanout`.

## Test plan
- Memory holds 0x100=0x80, all other bytes 0; ready always high; start → first pixel cycle 17 with `pix_data`=1 and `pix_sof`=1. All other 2047 pixels are 0; `scan_done` at cycle 2562.
- Checkerboard (0xAA rows alternating with 0x55 rows) → output stream matches the bit-exact raster; `pix_eol` is asserted exactly on every 64th pixel (32 times).
- `pix_ready` toggled pseudo-randomly → data and markers stay stable while stalled; no pixel is lost or duplicated; frame totals 2048 pixels.
- Ack delayed 0–5 cycles randomly → each read address is held until ack; 256 reads total, addresses 0x100–0x1FF in order.
- `rst` asserted mid-row 10 → next edge shows all outputs 0; a new start rescans from 0x100.
- With `FB_SCANOUT_ROW_DOUBLE_EN`: 4096 pixels; still 256 reads; `scan_done` at cycle 4610 with ready high.
